bnn_seq_ctrl: RTL

Sequencing controller for the serial BNN inference datapath (layer-1 signed accumulators, layer-2 XNOR popcount accumulators). It accepts one feature vector per inference over a valid/ready handshake and issues a synchronous clear to the datapath. It then steps the feature index for layer 1 and the hidden-bit index for layer 2, and finally runs a sequential argmax over the class sums. The class result is returned over a second valid/ready handshake, so back-to-back samples are processed without a global reset between them.

---
 rtl/bnn_seq_ctrl.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/bnn_seq_ctrl.sv
// Sequencing controller for the serial BNN datapath: accepts a feature vector,
// clears the datapath, steps layer-1 and layer-2 indices, then runs an argmax over the class sums.
module bnn_seq_ctrl #(
    parameter int unsigned N = 11,
    parameter int unsigned M = 40,
    parameter int unsigned B = 4,
    parameter int unsigned C = 6
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [N*B-1:0]                in_data,
    output logic                          dp_clear,
    output logic                          dp_l1_en,
    output logic [$clog2(N)-1:0]          dp_l1_idx,
    output logic [B-1:0]                  dp_x,
    output logic                          dp_l2_en,
    output logic [$clog2(M)-1:0]          dp_l2_idx,
    input  logic [C*$clog2(M+1)-1:0]      dp_sums,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [$clog2(C)-1:0]          out_class,
    output logic                          busy
);

    localparam int unsigned SumL = $clog2(M + 1);
    localparam int unsigned L1W  = $clog2(N);
    localparam int unsigned L2W  = $clog2(M);
    localparam int unsigned CW   = $clog2(C);
    localparam int unsigned CntW = (L2W > L1W) ? ((L2W > CW) ? L2W : CW)
                                               : ((L1W > CW) ? L1W : CW);

    typedef enum logic [2:0] {IDLE, CLEAR, L1, L2, ARG, DONE} state_t;

    state_t            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [N*B-1:0]    data_q, data_d;
    logic [SumL-1:0]   best_q, best_d, sum_k;
    logic [CW-1:0]     bidx_q, bidx_d, class_d;

    logic              in_ready_d, busy_d, clear_d, l1_en_d, l2_en_d, out_valid_d;
    logic [L1W-1:0]    l1_idx_d;
    logic [L2W-1:0]    l2_idx_d;
    logic [B-1:0]      x_d;

    // Next state, counters, argmax and next values of every registered output
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        best_d  = best_q;
        bidx_d  = bidx_q;
        class_d = out_class;
        sum_k   = '0;

        for (int j = 0; j < int'(C); j++) begin
            if (cnt_q == CntW'(j)) sum_k = dp_sums[j*SumL +: SumL];
        end

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    data_d  = in_data;
                    state_d = CLEAR;
                end
            end
            CLEAR: begin
                cnt_d   = '0;
                state_d = L1;
            end
            L1: begin
                if (cnt_q == CntW'(N - 1)) begin
                    cnt_d   = '0;
                    state_d = L2;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            L2: begin
                if (cnt_q == CntW'(M - 1)) begin
                    cnt_d   = '0;
                    state_d = ARG;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            ARG: begin
                // Strict compare keeps the lowest index on ties
                if (cnt_q == '0 || sum_k > best_q) begin
                    best_d = sum_k;
                    bidx_d = CW'(cnt_q);
                end
                if (cnt_q == CntW'(C - 1)) begin
                    class_d = bidx_d;
                    cnt_d   = '0;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase

        in_ready_d  = (state_d == IDLE);
        busy_d      = (state_d != IDLE);
        clear_d     = (state_d == CLEAR);
        l1_en_d     = (state_d == L1);
        l2_en_d     = (state_d == L2);
        out_valid_d = (state_d == DONE);
        l1_idx_d    = (state_d == L1) ? L1W'(cnt_d) : '0;
        l2_idx_d    = (state_d == L2) ? L2W'(cnt_d) : '0;

        x_d = '0;
        if (state_d == L1) begin
            for (int k = 0; k < int'(N); k++) begin
                if (cnt_d == CntW'(k)) x_d = data_d[k*B +: B];
            end
        end
    end

    // State and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            data_q    <= '0;
            best_q    <= '0;
            bidx_q    <= '0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
            dp_clear  <= 1'b0;
            dp_l1_en  <= 1'b0;
            dp_l2_en  <= 1'b0;
            dp_l1_idx <= '0;
            dp_l2_idx <= '0;
            dp_x      <= '0;
            out_valid <= 1'b0;
            out_class <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            data_q    <= data_d;
            best_q    <= best_d;
            bidx_q    <= bidx_d;
            in_ready  <= in_ready_d;
            busy      <= busy_d;
            dp_clear  <= clear_d;
            dp_l1_en  <= l1_en_d;
            dp_l2_en  <= l2_en_d;
            dp_l1_idx <= l1_idx_d;
            dp_l2_idx <= l2_idx_d;
            dp_x      <= x_d;
            out_valid <= out_valid_d;
            out_class <= class_d;
        end
    end

endmodule
